// File: rtl/spi_nn_master.sv
// SPI initiator: turns one command into a 32-bit {rw,addr,data} mode-0 frame, MSB first.
// Latency: ss_n low for 66*HALF_DIV clk cycles; next command GAP_CYCLES cycles after ss_n rises.
// Backpressure: cmd_ready high only in IDLE; requester holds cmd_* until accepted.
module spi_nn_master #(
  parameter int HALF_DIV   = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_addr,
  input  logic [23:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_rw,
  output logic [23:0] rsp_rdata,
  output logic        busy,
  output logic        sclk,
  output logic        ss_n,
  output logic        mosi,
  input  logic        miso
);

  localparam int CNT_MAX = (HALF_DIV > GAP_CYCLES) ? HALF_DIV : GAP_CYCLES;
  localparam int DIV_W   = $clog2(CNT_MAX + 1);
  // Last count value of one sclk half-period.
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(HALF_DIV - 1);
  // GAP state covers GAP_CYCLES-1 cycles; the mandatory IDLE cycle completes the gap.
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  // Remaining frame bits 30:0; bit 31 (rw) goes straight to mosi at acceptance.
  logic [30:0]      packet;
  // Only the last 24 samples matter, older ones fall off the top.
  logic [23:0]      shift_in;
  logic             rw_lat;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Frame sequencer: all SPI pins and response outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      packet    <= '0;
      shift_in  <= '0;
      rw_lat    <= 1'b0;
      sclk      <= 1'b0;
      ss_n      <= 1'b1;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rw    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            packet  <= {cmd_addr, cmd_wdata};
            rw_lat  <= cmd_rw;
            mosi    <= cmd_rw;
            ss_n    <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= LEAD;
          end
        end
        LEAD: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt  <= '0;
            sclk     <= 1'b1;
            shift_in <= {shift_in[22:0], miso};
            bit_cnt  <= 6'd1;
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt != HALF_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (sclk) begin
              // Falling edge: present the next bit, or park mosi after the last one.
              sclk <= 1'b0;
              if (bit_cnt == 6'd32) begin
                mosi <= 1'b0;
              end else begin
                mosi   <= packet[30];
                packet <= {packet[29:0], 1'b0};
              end
            end else if (bit_cnt == 6'd32) begin
              // Final low phase done; hold select for the trailing half-period.
              state <= TRAIL;
            end else begin
              sclk     <= 1'b1;
              shift_in <= {shift_in[22:0], miso};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
        TRAIL: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt   <= '0;
            ss_n      <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rw    <= rw_lat;
            rsp_rdata <= shift_in;
            state     <= (GAP_CYCLES > 1) ? GAP : IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_nn_master.sv
// Bench for spi_nn_master: two instances (HALF_DIV=2/GAP=4 and HALF_DIV=1/GAP=1).
// A frame-timing model predicts every output each cycle; a slave model feeds miso.
// Directed frames pin the model with literal values, then random commands follow.
module tb_spi_nn_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_w [2];
  logic        cv_w    [2];
  logic        rw_w    [2];
  logic [6:0]  addr_w  [2];
  logic [23:0] wd_w    [2];
  logic        miso_w  [2];
  logic        rdy_w   [2];
  logic        rv_w    [2];
  logic        rrw_w   [2];
  logic [23:0] rd_w    [2];
  logic        busy_w  [2];
  logic        sclk_w  [2];
  logic        ss_w    [2];
  logic        mosi_w  [2];

  spi_nn_master #(.HALF_DIV(2), .GAP_CYCLES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n_w[0]), .cmd_valid(cv_w[0]), .cmd_ready(rdy_w[0]),
    .cmd_rw(rw_w[0]), .cmd_addr(addr_w[0]), .cmd_wdata(wd_w[0]),
    .rsp_valid(rv_w[0]), .rsp_rw(rrw_w[0]), .rsp_rdata(rd_w[0]), .busy(busy_w[0]),
    .sclk(sclk_w[0]), .ss_n(ss_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0]));

  spi_nn_master #(.HALF_DIV(1), .GAP_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n_w[1]), .cmd_valid(cv_w[1]), .cmd_ready(rdy_w[1]),
    .cmd_rw(rw_w[1]), .cmd_addr(addr_w[1]), .cmd_wdata(wd_w[1]),
    .rsp_valid(rv_w[1]), .rsp_rw(rrw_w[1]), .rsp_rdata(rd_w[1]), .busy(busy_w[1]),
    .sclk(sclk_w[1]), .ss_n(ss_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1]));

  int cyc;
  int nvec;
  int nfail;

  // Frame model: accepted packet plus cycles elapsed since acceptance.
  bit          in_frame [2];
  int          t_m      [2];
  logic [31:0] pkt_m    [2];
  logic [31:0] sf_m     [2];
  logic        exp_rw   [2];
  logic [23:0] exp_rd   [2];
  int          acc_cnt  [2];
  logic [31:0] sframe   [2];

  // Observed-waveform measurements and slave shift register.
  logic        prev_ss    [2];
  logic        prev_sclk  [2];
  logic [31:0] cap        [2];
  logic [31:0] last_cap   [2];
  logic [31:0] ssr        [2];
  int          rises      [2];
  int          last_rises [2];
  int          lowcnt     [2];
  int          last_low   [2];
  int          highcnt    [2];
  int          min_high   [2];
  int          fall_cyc   [2];
  int          spacing    [2];
  int          rsp_cnt    [2];

  function automatic int hd(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int gc(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  // Advance the model by one clock edge, compare all outputs, then update slave/monitors.
  task automatic step(input int i);
    int h, fl, p;
    bit ready_prev;
    logic e_ss, e_sclk, e_mosi, e_rv, e_busy;
    logic [30:0] got, want;
    h  = hd(i);
    fl = 66 * h;
    if (!rst_n_w[i]) begin
      in_frame[i] = 1'b0;
      t_m[i]      = 0;
      exp_rw[i]   = 1'b0;
      exp_rd[i]   = '0;
    end else begin
      ready_prev = !in_frame[i] || (t_m[i] >= fl + gc(i) - 1);
      if (ready_prev && cv_w[i]) begin
        in_frame[i] = 1'b1;
        t_m[i]      = 0;
        pkt_m[i]    = {rw_w[i], addr_w[i], wd_w[i]};
        sf_m[i]     = sframe[i];
        acc_cnt[i]++;
      end else if (in_frame[i]) begin
        if (t_m[i] < fl + gc(i)) t_m[i]++;
        if (t_m[i] == fl) begin
          exp_rw[i] = pkt_m[i][31];
          exp_rd[i] = sf_m[i][23:0];
        end
      end
    end
    p      = t_m[i] / h;
    e_ss   = !(in_frame[i] && t_m[i] < fl);
    e_sclk = in_frame[i] && (t_m[i] < 64 * h) && (p % 2 == 1);
    e_mosi = (in_frame[i] && t_m[i] < 64 * h) ? pkt_m[i][31 - p / 2] : 1'b0;
    e_rv   = in_frame[i] && (t_m[i] == fl);
    e_busy = in_frame[i] && (t_m[i] < fl + gc(i) - 1);
    want = {e_ss, e_sclk, e_mosi, e_rv, !e_busy, e_busy, exp_rw[i], exp_rd[i]};
    got  = {ss_w[i], sclk_w[i], mosi_w[i], rv_w[i], rdy_w[i], busy_w[i], rrw_w[i], rd_w[i]};
    check((i == 0) ? "outputs0" : "outputs1", {1'b0, got}, {1'b0, want});

    if (prev_ss[i] && !ss_w[i]) begin
      cap[i]    = '0;
      rises[i]  = 0;
      lowcnt[i] = 0;
      if (fall_cyc[i] >= 0) spacing[i] = cyc - fall_cyc[i];
      fall_cyc[i] = cyc;
      if (highcnt[i] < min_high[i]) min_high[i] = highcnt[i];
      highcnt[i] = 0;
      ssr[i]     = sframe[i];
    end else if (prev_sclk[i] && !sclk_w[i] && !ss_w[i]) begin
      ssr[i] = {ssr[i][30:0], 1'b0};
    end
    if (!ss_w[i]) lowcnt[i]++;
    else highcnt[i]++;
    if (sclk_w[i] && !prev_sclk[i]) begin
      cap[i] = {cap[i][30:0], mosi_w[i]};
      rises[i]++;
    end
    if (rv_w[i]) begin
      rsp_cnt[i]++;
      last_cap[i]   = cap[i];
      last_low[i]   = lowcnt[i];
      last_rises[i] = rises[i];
    end
    miso_w[i]    = ssr[i][31];
    prev_ss[i]   = ss_w[i];
    prev_sclk[i] = sclk_w[i];
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) step(i);
    #1;
  endtask

  task automatic send(input int i, input logic rw, input logic [6:0] a, input logic [23:0] d,
                      input logic [31:0] sf, input bit hold);
    int n0, k;
    n0 = acc_cnt[i];
    k  = 0;
    rw_w[i]   = rw;
    addr_w[i] = a;
    wd_w[i]   = d;
    sframe[i] = sf;
    cv_w[i]   = 1'b1;
    while (acc_cnt[i] == n0 && k < 400) begin
      tick();
      k++;
    end
    check("accept", acc_cnt[i] - n0, 1);
    if (!hold) cv_w[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input int n);
    int k;
    k = 0;
    while (rsp_cnt[i] < n && k < 600) begin
      tick();
      k++;
    end
    check("rsp_count", rsp_cnt[i], n);
  endtask

  task automatic random_cmds(input int i, input int count);
    bit hold;
    for (int c = 0; c < count; c++) begin
      hold = (c != count - 1) && ($urandom_range(0, 1) == 1);
      send(i, 1'($urandom), 7'($urandom), 24'($urandom), $urandom, hold);
      if (!hold) begin
        for (int g = 0; g < int'($urandom_range(0, 5)); g++) tick();
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    cyc = 0; nvec = 0; nfail = 0;
    for (int i = 0; i < 2; i++) begin
      in_frame[i] = 1'b0; t_m[i] = 0; pkt_m[i] = '0; sf_m[i] = '0;
      exp_rw[i] = 1'b0; exp_rd[i] = '0; acc_cnt[i] = 0; sframe[i] = '0;
      prev_ss[i] = 1'b1; prev_sclk[i] = 1'b0; cap[i] = '0; last_cap[i] = '0; ssr[i] = '0;
      rises[i] = 0; last_rises[i] = 0; lowcnt[i] = 0; last_low[i] = 0; highcnt[i] = 0;
      min_high[i] = 1000; fall_cyc[i] = -1; spacing[i] = 0; rsp_cnt[i] = 0;
      rst_n_w[i] = 1'b0; miso_w[i] = 1'b0;
      rw_w[i] = 1'b0; addr_w[i] = '0; wd_w[i] = '0;
    end
    // Reset held with a command pending: nothing may start.
    cv_w[0] = 1'b1; rw_w[0] = 1'b0; addr_w[0] = 7'h10; wd_w[0] = 24'hA5C3F0;
    sframe[0] = 32'h5A5A5A5A;
    cv_w[1] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("reset_ss_n", ss_w[0], 1'b1);
    check("reset_ready", rdy_w[0], 1'b1);
    cv_w[1] = 1'b0;
    rst_n_w[0] = 1'b1;

    // Write frame
    send(0, 1'b0, 7'h10, 24'hA5C3F0, 32'h5A5A5A5A, 1'b0);
    wait_rsp(0, 1);
    check("wr_mosi", last_cap[0], 32'h10A5C3F0);
    check("wr_ss_low", last_low[0], 132);
    check("wr_pulses", last_rises[0], 32);
    check("wr_rsp_rw", rrw_w[0], 1'b0);
    check("wr_rdata", rd_w[0], 24'h5A5A5A);

    // Read frame
    send(0, 1'b1, 7'h02, 24'($urandom), {8'($urandom), 24'h00000B}, 1'b0);
    wait_rsp(0, 2);
    check("rd_hdr", last_cap[0][31:24], 8'h82);
    check("rd_data", rd_w[0], 24'h00000B);
    check("rd_rsp_rw", rrw_w[0], 1'b1);

    // Back-to-back with cmd_valid held
    min_high[0] = 1000;
    send(0, 1'b0, 7'h00, 24'h111111, $urandom, 1'b1);
    send(0, 1'b0, 7'h01, 24'h222222, $urandom, 1'b1);
    send(0, 1'b1, 7'h11, 24'h333333, $urandom, 1'b0);
    wait_rsp(0, 5);
    check("b2b_spacing", spacing[0], 136);
    check("b2b_gap", min_high[0], 4);
    check("b2b_last_hdr", last_cap[0][31:24], 8'h91);

    // Reset after the 10th sclk rise aborts the frame
    n = rsp_cnt[0];
    send(0, 1'b0, 7'h33, 24'h0F0F0F, $urandom, 1'b0);
    for (int k = 0; k < 100 && rises[0] < 10; k++) tick();
    check("abort_rise", rises[0], 10);
    rst_n_w[0] = 1'b0;
    tick();
    rst_n_w[0] = 1'b1;
    check("abort_pins", {ss_w[0], sclk_w[0]}, 2'b10);
    for (int k = 0; k < 150; k++) tick();
    check("abort_no_rsp", rsp_cnt[0], n);
    send(0, 1'b0, 7'h44, 24'h123456, $urandom, 1'b0);
    wait_rsp(0, n + 1);
    check("post_abort_pulses", last_rises[0], 32);
    check("post_abort_low", last_low[0], 132);
    check("post_abort_mosi", last_cap[0], 32'h44123456);

    n = rsp_cnt[0];
    random_cmds(0, 12);
    wait_rsp(0, n + 12);

    // Fastest configuration
    rst_n_w[1] = 1'b1;
    tick();
    send(1, 1'b0, 7'h7F, 24'hFFFFFF, $urandom, 1'b0);
    wait_rsp(1, 1);
    check("fast_mosi", last_cap[1], 32'h7FFFFFFF);
    check("fast_ss_low", last_low[1], 66);
    check("fast_pulses", last_rises[1], 32);
    min_high[1] = 1000;
    send(1, 1'b1, 7'h05, 24'h00C0DE, $urandom, 1'b1);
    send(1, 1'b0, 7'h06, 24'hBEEF00, $urandom, 1'b0);
    wait_rsp(1, 3);
    check("fast_spacing", spacing[1], 67);
    check("fast_gap", min_high[1], 1);

    n = rsp_cnt[1];
    random_cmds(1, 12);
    wait_rsp(1, n + 12);
    for (int k = 0; k < 10; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
